bin_search_controller: RTL and testbench
========================================

# bin_search_controller

Acquisition and tracking controller for the despread-bin datapath of the 802.11b 1 Mbps DSSS receiver. It consumes the per-bin despread I/Q stream and accumulates per-bin energy over a programmable number of symbol sweeps. It then selects the strongest bin and drives `max_bin_index` / `max_index_valid_out` to the downstream DBPSK demodulator. Once locked, it monitors the chosen bin and re-acquires when energy drops.

## Interface
Parameters:
- `NUM_BINS`, 8: number of despread bins per sweep; bins are 0..NUM_BINS-1.
- `ACC_SYMBOLS`, 4: complete sweeps accumulated per acquisition or tracking window.
- `ACC_W`, 40: accumulator width, unsigned, saturating.
- `MAX_RETRIES`, 3: number of failed searches allowed before giving up.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled; leaves IDLE.
- `stop`  in  1  forces IDLE from any state; wins over `start`.
- `threshold`  in  ACC_W  minimum winning-bin energy required to declare lock.
- `despread_sample_i`, `despread_sample_q`  in  32 signed  despread sample.
- `despread_sample_valid`  in  1  sample qualifier.
- `out_bin_index`  in  16  bin tag of the current sample.
- `max_bin_index`  out  16  selected bin.
- `max_index_valid_out`  out  1  high while LOCKED.
- `locked`  out  1  equals (state==LOCKED).
- `search_fail`  out  1  one-cycle pulse when retries are exhausted.
- `state_out`  out  2  IDLE=0, ACCUM=1, SEARCH=2, LOCKED=3.

## Operation
- **Energy metric:** e = |I| + |Q|, 33 bits unsigned.
  - |x| of -2^31 saturates to 2^31-1.
  - e is zero-extended to ACC_W.
  - All accumulator adds saturate at 2^ACC_W-1 and never wrap.
- **Accepted sample:** `despread_sample_valid`=1 and `out_bin_index` < NUM_BINS. Out-of-range indices are ignored entirely, including for sweep counting.
- **Sweep boundary:** an accepted sample with `out_bin_index`==NUM_BINS-1.
- **IDLE:**
  - Outputs are deasserted, the energy array is cleared, and `retry_cnt`=0.
  - `start`=1 and `stop`=0 leads to ACCUM.
- **ACCUM:**
  - Each accepted sample does `acc[bin] += e`.
  - The sweep counter increments at each sweep boundary.
  - When the boundary completing sweep ACC_SYMBOLS is accepted, its energy is added first, then the state goes to SEARCH.
- **SEARCH:**
  - Scans `acc[0..NUM_BINS-1]`, one bin per cycle, keeping the running max and its index.
  - Update rule is strict greater-than, so ties resolve to the lowest index.
  - All input samples are dropped during SEARCH.
  - On the cycle after the last bin is compared:
    - If max >= `threshold`: go to LOCKED, latch `max_bin_index`, and clear the tracking accumulator and sweep counter.
    - Else: `retry_cnt`++, clear the array and sweep counter. If `retry_cnt` reaches MAX_RETRIES, pulse `search_fail` and go to IDLE; otherwise go to ACCUM.
- **LOCKED:**
  - Only accepted samples with `out_bin_index`==`max_bin_index` add into `track_acc`. Sweep boundaries count as in ACCUM.
  - After ACC_SYMBOLS sweeps:
    - If `track_acc` < (`threshold` >> 1): lock is lost. Clear the array, `track_acc` and `retry_cnt`, and go to ACCUM.
    - Else: clear `track_acc` and the sweep counter, and stay in LOCKED.
  - `max_bin_index` holds its value until the next successful search.
- **stop:** any state goes to IDLE on the next edge. This clears all counters and accumulators and deasserts `max_index_valid_out`.
- **Threshold of 0:** always locks after the first window.

## Timing
- Reset behaviour: on `reset`=1 at a clock edge, all outputs, accumulators and counters are zero next cycle, and the state is IDLE. Reset mid-SEARCH or mid-LOCKED aborts with no pulses.
- Accumulator write: registered; `acc` reflects a sample 1 cycle after it is presented.
- Transition out of ACCUM: occurs on the edge that accepts the final boundary sample.
- SEARCH latency: NUM_BINS compare cycles plus 1 decision cycle.
  - `max_index_valid_out`, `locked` and `max_bin_index` are updated together on the decision edge.
  - They are visible NUM_BINS+1 cycles after SEARCH entry.
- `search_fail`: high for exactly the single cycle following the decision edge; IDLE is entered at the same edge.
- Lock loss: `max_index_valid_out` falls on the edge that accepts the window-ending boundary sample.
- Back-to-back samples: accepted every cycle with no stall; there is no backpressure.
- Simultaneous events:
  - `stop` together with `start`: IDLE.
  - `stop` together with the lock decision: IDLE, with no lock or fail output.

## Test plan
- **Basic lock:** NUM_BINS=8, ACC_SYMBOLS=4, threshold=1000. Feed 4 sweeps with bin 5 at I=300, Q=-100 and the other bins at I=10, Q=10 → `acc[5]`=1600, `max_bin_index`=5, `max_index_valid_out`=1 exactly 9 cycles after SEARCH entry.
- **Tie-break:** bins 2 and 6 both have energy 2000 → `max_bin_index`=2.
- **Retry exhaustion:** every bin at I=1, Q=1, threshold=1000, MAX_RETRIES=3 → three SEARCH passes, one `search_fail` pulse, state_out=0, `max_index_valid_out` never asserted.
- **Lock loss:** lock on bin 5, then drive bin 5 at I=50, Q=0 for 4 sweeps (track_acc=200 < 500) → `max_index_valid_out` falls and state_out=1. A strong bin 3 then relocks with `max_bin_index`=3.
- **Saturation and ignored inputs:**
  - Feed I=-2^31, Q=-2^31 with ACC_W=34 → accumulator saturates at 2^34-1 with no wrap.
  - Samples tagged `out_bin_index`=9 change no state and no counter.
- **Control preemption:** assert `stop` mid-SEARCH and `reset` mid-LOCKED → IDLE next cycle, all outputs 0, no `search_fail` pulse.

Source files
------------

// File: rtl/bin_search_controller.sv
// Per-bin energy accumulation, strongest-bin search and lock tracking for the DSSS despread stream.
// Accumulators update 1 cycle after a sample; lock decision lands NUM_BINS+1 cycles after search entry; no backpressure.
module bin_search_controller #(
   parameter int NUM_BINS    = 8,
   parameter int ACC_SYMBOLS = 4,
   parameter int ACC_W       = 40,
   parameter int MAX_RETRIES = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic [ACC_W-1:0]   threshold,
   input  logic signed [31:0] despread_sample_i,
   input  logic signed [31:0] despread_sample_q,
   input  logic               despread_sample_valid,
   input  logic [15:0]        out_bin_index,
   output logic [15:0]        max_bin_index,
   output logic               max_index_valid_out,
   output logic               locked,
   output logic               search_fail,
   output logic [1:0]         state_out
);
   localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam int BIN_W = $clog2(NUM_BINS + 1);
   localparam int SWP_W = $clog2(ACC_SYMBOLS + 1);
   localparam int RTY_W = $clog2(MAX_RETRIES + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SEARCH = 2'd2, LOCKED = 2'd3} state_t;

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc [NUM_BINS];
   logic [ACC_W-1:0]   track_acc, run_max, e_ext, acc_sum, track_sum;
   logic [IDX_W-1:0]   run_idx, bin_idx;
   logic [BIN_W-1:0]   scan_cnt;
   logic [SWP_W-1:0]   sweep_cnt;
   logic [RTY_W-1:0]   retry_cnt;
   logic [32:0]        energy;
   logic               accepted, boundary, window_done, scan_done, lock_ok, retry_last, lock_lost;

   // |-2^31| is clamped so the magnitude always fits 31 bits.
   function automatic logic [31:0] mag(input logic signed [31:0] x);
      if (x == 32'sh8000_0000) return 32'h7FFF_FFFF;
      else if (x < 0)          return 32'(-x);
      else                     return 32'(x);
   endfunction

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[ACC_W] ? '1 : s[ACC_W-1:0];
   endfunction

   always_comb begin
      energy      = {1'b0, mag(despread_sample_i)} + {1'b0, mag(despread_sample_q)};
      e_ext       = ACC_W'(energy);
      bin_idx     = out_bin_index[IDX_W-1:0];
      accepted    = despread_sample_valid && (out_bin_index < 16'(NUM_BINS));
      boundary    = accepted && (out_bin_index == 16'(NUM_BINS - 1));
      window_done = boundary && (sweep_cnt == SWP_W'(ACC_SYMBOLS - 1));
      scan_done   = (scan_cnt == BIN_W'(NUM_BINS));
      lock_ok     = (run_max >= threshold);
      retry_last  = (retry_cnt == RTY_W'(MAX_RETRIES - 1));
      acc_sum     = sat_add(acc[bin_idx], e_ext);
      track_sum   = (accepted && (out_bin_index == max_bin_index)) ? sat_add(track_acc, e_ext) : track_acc;
      lock_lost   = window_done && (track_sum < (threshold >> 1));
   end

   always_comb begin
      state_nxt = state;
      if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start)       state_nxt = ACCUM;
            ACCUM:   if (window_done) state_nxt = SEARCH;
            SEARCH:  if (scan_done)   state_nxt = lock_ok ? LOCKED : (retry_last ? IDLE : ACCUM);
            LOCKED:  if (lock_lost)   state_nxt = ACCUM;
            default:                  state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset || stop || state == IDLE) begin
         for (int b = 0; b < NUM_BINS; b++) acc[b] <= '0;
         track_acc     <= '0;
         run_max       <= '0;
         run_idx       <= '0;
         scan_cnt      <= '0;
         sweep_cnt     <= '0;
         retry_cnt     <= '0;
         max_bin_index <= '0;
         search_fail   <= 1'b0;
      end else begin
         search_fail <= 1'b0;
         case (state)
            ACCUM: begin
               scan_cnt <= '0;
               run_max  <= '0;
               run_idx  <= '0;
               if (accepted) acc[bin_idx] <= acc_sum;
               if (boundary) sweep_cnt <= window_done ? '0 : sweep_cnt + 1'b1;
            end
            SEARCH: begin
               if (!scan_done) begin
                  // Strict compare keeps the lowest index on ties.
                  if (acc[scan_cnt[IDX_W-1:0]] > run_max) begin
                     run_max <= acc[scan_cnt[IDX_W-1:0]];
                     run_idx <= scan_cnt[IDX_W-1:0];
                  end
                  scan_cnt <= scan_cnt + 1'b1;
               end else if (lock_ok) begin
                  max_bin_index <= 16'(run_idx);
                  track_acc     <= '0;
                  sweep_cnt     <= '0;
               end else begin
                  for (int b = 0; b < NUM_BINS; b++) acc[b] <= '0;
                  retry_cnt   <= retry_cnt + 1'b1;
                  sweep_cnt   <= '0;
                  search_fail <= retry_last;
               end
            end
            LOCKED: begin
               track_acc <= track_sum;
               if (boundary) begin
                  if (window_done) begin
                     sweep_cnt <= '0;
                     track_acc <= '0;
                     if (lock_lost) begin
                        for (int b = 0; b < NUM_BINS; b++) acc[b] <= '0;
                        retry_cnt <= '0;
                     end
                  end else begin
                     sweep_cnt <= sweep_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign locked              = (state == LOCKED);
   assign max_index_valid_out = (state == LOCKED);
   assign state_out           = state;
endmodule

// File: tb/tb_bin_search_controller.sv
// Bench for bin_search_controller: lock events and search_fail pulses are scored against a queue of expected bins.
module tb_bin_search_controller;
   localparam int          NB       = 8;
   localparam logic [15:0] FAIL_TAG = 16'hFFFF;
   localparam int          MIN_I    = 32'sh8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, start, stop, valid;
   logic [39:0]        threshold;
   logic signed [31:0] si, sq;
   logic [15:0]        bin;
   logic [15:0]        max_bin;
   logic               vld_out, locked, search_fail;
   logic [1:0]         state;

   logic               s_start, s_stop;
   logic [33:0]        s_thr;
   logic [15:0]        s_max;
   logic               s_vld, s_locked, s_fail;
   logic [1:0]         s_state;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;
   logic        prev_locked = 1'b0;

   bin_search_controller dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .threshold(threshold),
      .despread_sample_i(si), .despread_sample_q(sq), .despread_sample_valid(valid),
      .out_bin_index(bin), .max_bin_index(max_bin), .max_index_valid_out(vld_out),
      .locked(locked), .search_fail(search_fail), .state_out(state)
   );

   bin_search_controller #(.NUM_BINS(8), .ACC_SYMBOLS(4), .ACC_W(34), .MAX_RETRIES(3)) dut_sat (
      .clk(clk), .reset(reset), .start(s_start), .stop(s_stop), .threshold(s_thr),
      .despread_sample_i(si), .despread_sample_q(sq), .despread_sample_valid(valid),
      .out_bin_index(bin), .max_bin_index(s_max), .max_index_valid_out(s_vld),
      .locked(s_locked), .search_fail(s_fail), .state_out(s_state)
   );

   // Scoreboard: each lock rise or search_fail pulse consumes one expected entry.
   always @(negedge clk) begin
      if (locked && !prev_locked) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL lock_event: unexpected lock on bin %0d, required no event", max_bin);
         end else begin
            mon_exp = exp_q.pop_front();
            if (max_bin !== mon_exp) $display("FAIL lock_event: locked bin %0d, required %0d", max_bin, mon_exp);
            else n_pass++;
         end
      end
      if (search_fail) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL fail_event: unexpected search_fail pulse, required no event");
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_exp !== FAIL_TAG) $display("FAIL fail_event: search_fail pulse, required lock on bin %0d", mon_exp);
            else n_pass++;
         end
      end
      prev_locked = locked;
   end

   task automatic send_v(input logic v, input int b, input int i, input int q);
      bin = 16'(b); si = i; sq = q; valid = v;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic send(input int b, input int i, input int q);
      send_v(1'b1, b, i, q);
   endtask

   task automatic sweep(input int sb, input int sb2, input int sbi, input int sbq, input int wi, input int wq);
      for (int b = 0; b < NB; b++) begin
         if (b == sb || b == sb2) send(b, sbi, sbq);
         else send(b, wi, wq);
      end
   endtask

   task automatic pulse_start;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic pulse_stop;
      stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
   endtask

   task automatic wait_lock(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         if (locked) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_checks++;
      if ({state, locked, vld_out, search_fail, max_bin} !== 21'd0)
         $display("FAIL reset_outputs: state=%0d locked=%0b vld=%0b fail=%0b bin=%0d, required all 0",
                  state, locked, vld_out, search_fail, max_bin);
      else n_pass++;
      n_checks++;
      if (dut.acc[3] !== 40'd0) $display("FAIL reset_acc: acc[3]=%0d required 0", dut.acc[3]);
      else n_pass++;
      @(posedge clk); #1; reset = 1'b0;
   endtask

   task automatic test_basic_lock;
      threshold = 40'd1000;
      pulse_start();
      @(negedge clk);
      n_checks++;
      if (state !== 2'd1) $display("FAIL basic_accum: state=%0d required 1", state); else n_pass++;
      exp_q.push_back(16'd5);
      for (int s = 0; s < 4; s++) sweep(5, -1, 300, -100, 10, 10);
      @(negedge clk);
      n_checks++;
      if (state !== 2'd2) $display("FAIL basic_search_entry: state=%0d required 2", state); else n_pass++;
      n_checks++;
      if (dut.acc[5] !== 40'd1600 || dut.acc[0] !== 40'd80)
         $display("FAIL basic_acc: acc[5]=%0d acc[0]=%0d required 1600 80", dut.acc[5], dut.acc[0]);
      else n_pass++;
      repeat (8) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (locked !== 1'b0) $display("FAIL basic_early_lock: locked=%0b required 0 at 8 cycles", locked); else n_pass++;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (locked !== 1'b1 || vld_out !== 1'b1 || state !== 2'd3 || max_bin !== 16'd5)
         $display("FAIL basic_lock: locked=%0b vld=%0b state=%0d bin=%0d required 1 1 3 5", locked, vld_out, state, max_bin);
      else n_pass++;
   endtask

   task automatic test_lock_loss;
      bit ok;
      for (int s = 0; s < 3; s++) sweep(5, -1, 50, 0, 10, 10);
      @(negedge clk);
      n_checks++;
      if (vld_out !== 1'b1) $display("FAIL loss_hold: vld=%0b required 1 before window end", vld_out); else n_pass++;
      sweep(5, -1, 50, 0, 10, 10);
      @(negedge clk);
      n_checks++;
      if (vld_out !== 1'b0 || state !== 2'd1)
         $display("FAIL loss_drop: vld=%0b state=%0d required 0 1", vld_out, state);
      else n_pass++;
      exp_q.push_back(16'd3);
      for (int s = 0; s < 4; s++) sweep(3, -1, 1000, 0, 10, 10);
      wait_lock(12, ok);
      n_checks++;
      if (!ok || max_bin !== 16'd3) $display("FAIL relock: locked=%0b bin=%0d required 1 3", ok, max_bin);
      else n_pass++;
   endtask

   task automatic test_stop;
      bit seen;
      pulse_stop();
      @(negedge clk);
      n_checks++;
      if (state !== 2'd0 || vld_out !== 1'b0 || max_bin !== 16'd0)
         $display("FAIL stop_locked: state=%0d vld=%0b bin=%0d required 0 0 0", state, vld_out, max_bin);
      else n_pass++;
      start = 1'b1; stop = 1'b1;
      @(posedge clk); #1; start = 1'b0; stop = 1'b0;
      @(negedge clk);
      n_checks++;
      if (state !== 2'd0) $display("FAIL stop_wins: state=%0d required 0", state); else n_pass++;
      pulse_start();
      for (int s = 0; s < 4; s++) sweep(2, -1, 1000, 0, 10, 10);
      repeat (3) @(posedge clk); #1;
      pulse_stop();
      @(negedge clk);
      n_checks++;
      if (state !== 2'd0 || locked !== 1'b0 || search_fail !== 1'b0 || max_bin !== 16'd0)
         $display("FAIL stop_mid_search: state=%0d locked=%0b fail=%0b bin=%0d required 0 0 0 0",
                  state, locked, search_fail, max_bin);
      else n_pass++;
      pulse_start();
      for (int s = 0; s < 4; s++) sweep(2, -1, 1000, 0, 10, 10);
      repeat (8) @(posedge clk); #1;
      pulse_stop();
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (locked || search_fail || state !== 2'd0) seen = 1'b1;
      end
      n_checks++;
      if (seen) $display("FAIL stop_at_decision: activity=%0b required 0", seen); else n_pass++;
   endtask

   task automatic test_tie_break;
      bit ok;
      pulse_start();
      exp_q.push_back(16'd2);
      for (int s = 0; s < 4; s++) sweep(2, 6, 300, -200, 10, 10);
      wait_lock(12, ok);
      n_checks++;
      if (!ok || max_bin !== 16'd2) $display("FAIL tie_break: locked=%0b bin=%0d required 1 2", ok, max_bin);
      else n_pass++;
   endtask

   task automatic test_reset_locked;
      bit seen;
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({state, locked, vld_out, search_fail, max_bin} !== 21'd0)
         $display("FAIL reset_locked: state=%0d locked=%0b vld=%0b fail=%0b bin=%0d required all 0",
                  state, locked, vld_out, search_fail, max_bin);
      else n_pass++;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (search_fail || locked) seen = 1'b1;
      end
      n_checks++;
      if (seen) $display("FAIL reset_quiet: activity=%0b required 0", seen); else n_pass++;
   endtask

   task automatic test_retry;
      bit ever;
      ever = 1'b0;
      exp_q.push_back(FAIL_TAG);
      pulse_start();
      for (int p = 0; p < 3; p++) begin
         for (int s = 0; s < 4; s++) sweep(-1, -1, 0, 0, 1, 1);
         @(negedge clk);
         n_checks++;
         if (state !== 2'd2) $display("FAIL retry_search_%0d: state=%0d required 2", p, state); else n_pass++;
         repeat (9) begin
            @(posedge clk);
            if (vld_out) ever = 1'b1;
         end
         @(negedge clk);
         n_checks++;
         if (p < 2) begin
            if (state !== 2'd1 || search_fail !== 1'b0)
               $display("FAIL retry_pass_%0d: state=%0d fail=%0b required 1 0", p, state, search_fail);
            else n_pass++;
         end else begin
            if (state !== 2'd0 || search_fail !== 1'b1)
               $display("FAIL retry_exhaust: state=%0d fail=%0b required 0 1", state, search_fail);
            else n_pass++;
         end
      end
      @(negedge clk);
      n_checks++;
      if (search_fail !== 1'b0 || ever) $display("FAIL retry_pulse_width: fail=%0b vld_seen=%0b required 0 0", search_fail, ever);
      else n_pass++;
   endtask

   task automatic test_ignored;
      bit ok;
      pulse_start();
      exp_q.push_back(16'd5);
      for (int s = 0; s < 4; s++) begin
         for (int b = 0; b < NB; b++) begin
            send(9, MIN_I, MIN_I);
            send_v(1'b0, 7, MIN_I, MIN_I);
            if (b == 5) send(b, 300, -100); else send(b, 10, 10);
         end
         if (s == 2) begin
            @(negedge clk);
            n_checks++;
            if (state !== 2'd1) $display("FAIL ignored_sweeps: state=%0d required 1 after 3 sweeps", state); else n_pass++;
         end
      end
      @(negedge clk);
      n_checks++;
      if (state !== 2'd2 || dut.acc[5] !== 40'd1600 || dut.acc[7] !== 40'd80)
         $display("FAIL ignored_acc: state=%0d acc[5]=%0d acc[7]=%0d required 2 1600 80", state, dut.acc[5], dut.acc[7]);
      else n_pass++;
      wait_lock(12, ok);
      n_checks++;
      if (!ok) $display("FAIL ignored_lock: locked=%0b required 1", ok); else n_pass++;
      pulse_stop();
   endtask

   task automatic test_saturation;
      longint     one_e = 64'd4294967294;
      logic [33:0] exp_acc;
      s_thr = '1;
      s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0;
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 8; k++) begin
            send(0, MIN_I, MIN_I);
            if (s == 0 && k == 3) begin
               exp_acc = 34'(4 * one_e);
               @(negedge clk);
               n_checks++;
               if (dut_sat.acc[0] !== exp_acc) $display("FAIL sat_partial: acc=%0d required %0d", dut_sat.acc[0], exp_acc);
               else n_pass++;
            end
         end
         for (int b = 1; b < NB; b++) send(b, 0, 0);
      end
      @(negedge clk);
      exp_acc = '1;
      n_checks++;
      if (s_state !== 2'd2 || dut_sat.acc[0] !== exp_acc)
         $display("FAIL sat_full: state=%0d acc=%0d required 2 %0d", s_state, dut_sat.acc[0], exp_acc);
      else n_pass++;
      repeat (9) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (s_locked !== 1'b1 || s_max !== 16'd0) $display("FAIL sat_lock: locked=%0b bin=%0d required 1 0", s_locked, s_max);
      else n_pass++;
      s_stop = 1'b1; @(posedge clk); #1; s_stop = 1'b0;
      @(negedge clk);
      n_checks++;
      if (s_state !== 2'd0 || s_vld !== 1'b0 || s_fail !== 1'b0)
         $display("FAIL sat_stop: state=%0d vld=%0b fail=%0b required 0 0 0", s_state, s_vld, s_fail);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; valid = 1'b0; bin = '0; si = 0; sq = 0;
      threshold = '0; s_start = 1'b0; s_stop = 1'b0; s_thr = '0;
      repeat (3) @(posedge clk); #1;
      test_reset();
      test_basic_lock();
      test_lock_loss();
      test_stop();
      test_tie_break();
      test_reset_locked();
      test_retry();
      test_ignored();
      test_saturation();
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d events pending, required 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
